// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM.
// Takes one command (start address, beats-1, direction), then drives the RAM
// port one registered access per clock: writes are paced by a wr_valid/wr_ready
// stream, reads issue every cycle and come back one cycle later on rd_*.
module ram_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rw,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_done,
  output logic              o_ram_en,
  output logic              o_ram_rw,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;      // next address to access, wraps modulo depth
  logic [ADDR_W-1:0]   r_cnt;       // beats remaining minus one
  logic                r_is_rd;     // direction of the burst in flight
  logic                r_ram_en;
  logic                r_ram_rw;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_rd_valid;
  logic                r_rd_last;
  logic                r_done;
  logic                w_wr_hs;

  assign w_wr_hs     = (r_state == S_WR) && i_wr_valid;

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_wr_ready  = (r_state == S_WR);
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = i_ram_rdata;   // RAM output register already aligns with rd_valid
  assign o_rd_last   = r_rd_last;
  assign o_done      = r_done;
  assign o_ram_en    = r_ram_en;
  assign o_ram_rw    = r_ram_rw;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;

  // Burst FSM with registered RAM port and response flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_is_rd     <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // A read issued last cycle executes at this edge, so its data is valid next cycle.
      r_rd_valid <= r_ram_en && r_ram_rw;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ram_en <= 1'b0;
          if (i_cmd_valid) begin
            r_addr  <= i_cmd_addr;
            r_cnt   <= i_cmd_len;
            r_is_rd <= i_cmd_rw;
            r_state <= i_cmd_rw ? S_RD : S_WR;
          end
        end
        S_WR: begin
          if (w_wr_hs) begin
            r_ram_en    <= 1'b1;
            r_ram_rw    <= 1'b0;
            r_ram_addr  <= r_addr;
            r_ram_wdata <= i_wr_data;
            r_addr      <= r_addr + 1'b1;
            r_cnt       <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= S_WAIT;
          end else begin
            r_ram_en <= 1'b0;   // beat not consumed; address holds
          end
        end
        S_RD: begin
          r_ram_en   <= 1'b1;
          r_ram_rw   <= 1'b1;
          r_ram_addr <= r_addr;
          r_addr     <= r_addr + 1'b1;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Final access executes at this edge; flag completion for next cycle.
          r_ram_en  <= 1'b0;
          r_done    <= 1'b1;
          r_rd_last <= r_is_rd;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_ram_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 8x8 single-port RAM.
module tb_ram_burst_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid, rd_last, done;
  logic [DW-1:0] rd_data;
  logic          ram_en, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [8];
  int checks = 0, errors = 0, cyc = 0, en_cnt = 0, rdy_hi = 0;
  int wa[$], wd[$], we[$], rdd[$], rdl[$], rdn[$], rdc[$], dc[$];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last), .o_done(done),
    .o_ram_en(ram_en), .o_ram_rw(ram_rw), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Single-port RAM: rw=0 write, rw=1 registered read.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (!ram_rw) mem[ram_addr] <= ram_wdata;
      else         ram_rdata     <= mem[ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs, sampled mid-cycle; cyc is the index of the last edge.
  always @(negedge clk) begin
    if (ram_en) en_cnt++;
    if (ram_en && !ram_rw) begin
      wa.push_back(int'(ram_addr)); wd.push_back(int'(ram_wdata)); we.push_back(cyc + 1);
    end
    if (rd_valid) begin
      rdd.push_back(int'(rd_data)); rdl.push_back(int'(rd_last));
      rdn.push_back(int'(done));    rdc.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
  end

  task automatic clr;
    wa.delete(); wd.delete(); we.delete();
    rdd.delete(); rdl.delete(); rdn.delete(); rdc.delete(); dc.delete();
    en_cnt = 0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input bit rw, input int a, input int len, output int acc);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = AW'(a); cmd_len = AW'(len);
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    rdy_hi = 0;
    while (!done && n < 60) begin
      if (cmd_ready) rdy_hi++;
      tick(); n++;
    end
    if (cmd_ready) rdy_hi++;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles", n);
    end
    tick();
  endtask

  task automatic write_burst(input int a, input int len, input int base, input int step,
                             input bit gap, output int acc);
    int idx = 0, n = 0;
    bit ph = 1'b0, hs;
    send_cmd(1'b0, a, len, acc);
    while (idx <= len && n < 100) begin
      wr_valid = gap ? ph : 1'b1;
      wr_data  = DW'(base + step * idx);
      #0 hs = wr_valid && wr_ready;
      tick();
      if (hs) idx++;
      ph = ~ph; n++;
    end
    wr_valid = 1'b0;
    wait_done();
  endtask

  task automatic read_burst(input int a, input int len, output int acc);
    send_cmd(1'b1, a, len, acc);
    wait_done();
  endtask

  task automatic test_reset;
    #12;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b exp 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b exp 0", rd_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b exp 0", ram_en); end
    checks++; if (ram_rw !== 1'b1) begin errors++; $display("FAIL reset_ram_rw: got %b exp 1", ram_rw); end
    checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d exp 0", ram_addr); end
    checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %h exp 00", ram_wdata); end
    @(negedge clk); rst_n = 1'b1;
    clr();
    repeat (10) tick();
    checks++; if (en_cnt !== 0) begin errors++; $display("FAIL idle_ram_en: got %0d active cycles exp 0", en_cnt); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write_read;
    int acc;
    int ea[3] = '{2, 3, 4};
    int ed[3] = '{8'h11, 8'h22, 8'h33};
    clr();
    write_burst(2, 2, 8'h11, 8'h11, 1'b0, acc);
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL wr_count: got %0d exp 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i] || we[i] !== acc + 2 + i) begin
        errors++; $display("FAIL wr_beat%0d: got addr %0d data %h edge %0d exp addr %0d data %h edge %0d",
          i, (i < wa.size()) ? wa[i] : -1, (i < wd.size()) ? wd[i] : -1, (i < we.size()) ? we[i] : -1,
          ea[i], ed[i], acc + 2 + i);
      end
    end
    checks++; if (dc.size() !== 1 || dc[0] !== acc + 4) begin errors++; $display("FAIL wr_done_cycle: got %0d exp %0d", (dc.size() > 0) ? dc[0] : -1, acc + 4); end
    clr();
    read_burst(2, 2, acc);
    checks++; if (rdd.size() !== 3) begin errors++; $display("FAIL rd_count: got %0d exp 3", rdd.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rdd.size() || rdd[i] !== ed[i] || rdc[i] !== acc + 2 + i || rdl[i] !== int'(i == 2) || rdn[i] !== int'(i == 2)) begin
        errors++; $display("FAIL rd_beat%0d: got data %h cyc %0d last %0d done %0d exp data %h cyc %0d last/done %0d",
          i, (i < rdd.size()) ? rdd[i] : -1, (i < rdc.size()) ? rdc[i] : -1, (i < rdl.size()) ? rdl[i] : -1,
          (i < rdn.size()) ? rdn[i] : -1, ed[i], acc + 2 + i, int'(i == 2));
      end
    end
  endtask

  task automatic test_wrap;
    int acc;
    int ea[3] = '{6, 7, 0};
    clr();
    write_burst(6, 2, 8'hA1, 1, 1'b0, acc);
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL wrap_wr_count: got %0d exp 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== 8'hA1 + i) begin
        errors++; $display("FAIL wrap_wr%0d: got addr %0d data %h exp addr %0d data %h",
          i, (i < wa.size()) ? wa[i] : -1, (i < wd.size()) ? wd[i] : -1, ea[i], 8'hA1 + i);
      end
    end
    clr();
    read_burst(6, 2, acc);
    checks++; if (rdd.size() !== 3) begin errors++; $display("FAIL wrap_rd_count: got %0d exp 3", rdd.size()); end
    for (int i = 0; i < 3 && i < rdd.size(); i++) begin
      checks++;
      if (rdd[i] !== 8'hA1 + i) begin errors++; $display("FAIL wrap_rd%0d: got %h exp %h", i, rdd[i], 8'hA1 + i); end
    end
  endtask

  task automatic test_gap_write;
    int acc;
    clr();
    write_burst(0, 3, 8'h51, 1, 1'b1, acc);
    // wr_valid is low, high, low, high ... so handshakes land on every other edge
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL gap_en_cycles: got %0d exp 4", en_cnt); end
    checks++; if (wa.size() !== 4) begin errors++; $display("FAIL gap_wr_count: got %0d exp 4", wa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== i || wd[i] !== 8'h51 + i || we[i] !== acc + 3 + 2 * i) begin
        errors++; $display("FAIL gap_wr%0d: got addr %0d data %h edge %0d exp addr %0d data %h edge %0d",
          i, (i < wa.size()) ? wa[i] : -1, (i < wd.size()) ? wd[i] : -1, (i < we.size()) ? we[i] : -1,
          i, 8'h51 + i, acc + 3 + 2 * i);
      end
    end
    checks++; if (dc.size() !== 1 || dc[0] !== acc + 9) begin errors++; $display("FAIL gap_done_cycle: got %0d exp %0d", (dc.size() > 0) ? dc[0] : -1, acc + 9); end
  endtask

  task automatic test_full_read;
    int acc;
    write_burst(0, 7, 8'h40, 1, 1'b0, acc);
    clr();
    read_burst(0, 7, acc);
    checks++; if (rdd.size() !== 8) begin errors++; $display("FAIL full_rd_count: got %0d exp 8", rdd.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rdd.size() || rdd[i] !== 8'h40 + i || rdc[i] !== acc + 2 + i || rdl[i] !== int'(i == 7)) begin
        errors++; $display("FAIL full_rd%0d: got data %h cyc %0d last %0d exp data %h cyc %0d last %0d",
          i, (i < rdd.size()) ? rdd[i] : -1, (i < rdc.size()) ? rdc[i] : -1, (i < rdl.size()) ? rdl[i] : -1,
          8'h40 + i, acc + 2 + i, int'(i == 7));
      end
    end
    checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL full_cmd_ready_busy: got %0d ready cycles exp 0", rdy_hi); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_cmd_ready_after: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2;
    clr();
    read_burst(3, 0, acc1);
    read_burst(5, 0, acc2);
    // 1-beat read: done at acc+2, IDLE after acc+3, next accept at acc+4
    checks++; if (dc.size() < 1 || dc[0] !== acc1 + 2) begin errors++; $display("FAIL b2b_done1: got %0d exp %0d", (dc.size() > 0) ? dc[0] : -1, acc1 + 2); end
    checks++; if (acc2 !== acc1 + 4) begin errors++; $display("FAIL b2b_accept: got %0d exp %0d", acc2, acc1 + 4); end
    checks++; if (rdd.size() !== 2 || rdd[0] !== 8'h43 || rdd[1] !== 8'h45) begin
      errors++; $display("FAIL b2b_data: got %h,%h exp 43,45", (rdd.size() > 0) ? rdd[0] : -1, (rdd.size() > 1) ? rdd[1] : -1);
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    clr();
    send_cmd(1'b1, 0, 5, acc);
    repeat (3) tick();   // third beat issued at acc+3
    rst_n = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL mid_ram_en: got %b exp 0", ram_en); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b exp 0", done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got cmd_ready %b exp 1", cmd_ready); end
    @(negedge clk); rst_n = 1'b1;
    clr();
    repeat (10) tick();
    checks++; if (dc.size() !== 0 || en_cnt !== 0) begin errors++; $display("FAIL mid_quiet: got %0d done %0d en exp 0 0", dc.size(), en_cnt); end
    clr();
    read_burst(0, 7, acc);
    checks++; if (rdd.size() !== 8) begin errors++; $display("FAIL mid_rd_count: got %0d exp 8", rdd.size()); end
    for (int i = 0; i < 8 && i < rdd.size(); i++) begin
      checks++;
      if (rdd[i] !== 8'h40 + i) begin errors++; $display("FAIL mid_rd%0d: got %h exp %h", i, rdd[i], 8'h40 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_gap_write();
    test_full_read();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst initiator for the 8x8 single-port synchronous RAM (`en`/`rw`/`address`/`data_in`/`data_out`, `rw=0` write, `rw=1` read, one access per clock edge). Accepts a host command (start address, beat count, direction) through a valid/ready handshake. It then drives the RAM port cycle by cycle: write beats come from a handshaked write-data stream, and read beats are returned on a response stream. It sits between a host/test sequencer and the RAM, and owns all RAM port timing, including the RAM's one-cycle read latency.

## Interface
- ADDR_W, 3, RAM address width; RAM depth = 2^ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_rw  in  1  0 = write burst, 1 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  beats minus one (1..2^ADDR_W beats)
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted when high with wr_valid
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat present (no backpressure)
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  final beat of the read burst
- done  out  1  one-cycle pulse: burst complete
- ram_en  out  1  to RAM `en`
- ram_rw  out  1  to RAM `rw`
- ram_addr  out  ADDR_W  to RAM `address`
- ram_wdata  out  DATA_W  to RAM `data_in`
- ram_rdata  in  DATA_W  from RAM `data_out`

## Operation
- FSM states: IDLE, WR, RD, WAIT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr into the address counter and cmd_len into the beat counter. Go to WR if cmd_rw=0, or RD if cmd_rw=1.
- WR: wr_ready=1. On each wr_valid handshake edge, register ram_en=1, ram_rw=0, ram_addr=current address and ram_wdata=wr_data. Then increment the address and decrement the beat counter. With no handshake, register ram_en=0; the beat is not consumed.
- RD: on every edge, register ram_en=1, ram_rw=1 and ram_addr=current address, then increment/decrement as in WR. Reads never stall.
- When the final beat is registered (beat counter 0), go to WAIT. The final access is presented during WAIT. At the WAIT exit edge, register ram_en=0, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- cmd_ready=1 only in IDLE. wr_ready=1 only in WR.
- Address arithmetic is modulo 2^ADDR_W: 7 increments to 0, and a burst wraps through address 0.
- rd_valid is ram_en&&ram_rw delayed one cycle. rd_data is ram_rdata passed straight through. rd_last is high with the rd_valid of the final beat, which coincides with done.
- ram_wdata holds its last value when not writing. ram_addr holds its value when ram_en=0.
- Async reset (rst_n low), whether idle or mid-burst: state=IDLE, ram_en=0, ram_rw=1, ram_addr=0, ram_wdata=0, rd_valid=0, rd_last=0, done=0; both counters cleared. The burst is abandoned. RAM contents are not cleared and any beats already written persist.

## Timing
- Reset values: cmd_ready=1 (IDLE), wr_ready=0, rd_valid=0, rd_last=0, done=0, ram_en=0, ram_rw=1, ram_addr=0, ram_wdata=0.
- Command accept at edge E0. The state is WR/RD from the cycle after E0.
- Read burst of N beats: issues registered at E1..EN, RAM executes at E2..E(N+1), rd_valid high in the cycles after E2..E(N+1). Data comes out on N consecutive cycles with the first beat 3 cycles after accept. done/rd_last are high in the cycle after E(N+1). The FSM is back in IDLE after E(N+2).
- Write burst: each RAM write executes one edge after its wr handshake edge. done is high in the cycle after the edge executing the last write.
- Minimum spacing is back-to-back bursts, with the next command accepted in the cycle after done.
- A 1-beat read has done 3 cycles after accept.

## Test plan
- Reset, then idle → all outputs at reset values; cmd_ready=1; ram_en stays 0 for 10 cycles.
- Write addr 2, len 2, data 0x11,0x22,0x33 with wr_valid held high, then read addr 2, len 2 → RAM writes at 2,3,4; reads return 0x11,0x22,0x33 on 3 consecutive cycles; rd_last and done on 0x33.
- Write addr 6, len 2, data 0xA1,0xA2,0xA3 → ram_addr sequence 6,7,0; read addr 6 len 2 returns 0xA1,0xA2,0xA3.
- Write with wr_valid toggling every other cycle, len 3 → ram_en low during gaps, exactly 4 writes, done one cycle after the 4th write edge, no beat duplicated or lost.
- Full read addr 0, len 7 after filling with value = 0x40+address → 8 consecutive rd_valid beats 0x40..0x47; first beat 3 cycles after accept; cmd_ready low until after done.
- rst_n pulsed low during the 3rd beat of a 6-beat read → ram_en, rd_valid and done drop to 0 immediately, state returns to IDLE, no done pulse; a following read shows previously written RAM contents intact.
